// File: rtl/stopwatch_mode_ctrl_pkg.sv
// ---- stopwatch_mode_ctrl_pkg: state/event encodings and shared constants ----
// ---- rev 1.0 ----
`default_nettype none

package stopwatch_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  // Enumeration order doubles as the acting priority: lowest nonzero code wins.
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LR_LONG  = 3'd1,
    EV_SS_LONG  = 3'd2,
    EV_SS_PULSE = 3'd3,
    EV_LR_PULSE = 3'd4
  } event_e;

  localparam logic [3:0] DROP_SAT = 4'hF;

  function automatic event_e select_event(input logic lr_long, input logic ss_long,
                                          input logic ss_pulse, input logic lr_pulse);
    event_e ev;
    ev = EV_NONE;
    if (lr_long)       ev = EV_LR_LONG;
    else if (ss_long)  ev = EV_SS_LONG;
    else if (ss_pulse) ev = EV_SS_PULSE;
    else if (lr_pulse) ev = EV_LR_PULSE;
    return ev;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_mode_ctrl_lockout_timer.sv
// ---- lockout_timer: post-transition event lockout down-counter ----
// ---- rev 1.0 ----
`default_nettype none

module lockout_timer #(
  parameter int LOCKOUT = 4,
  parameter int LW      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LW'(LOCKOUT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/stopwatch_mode_ctrl.sv
// ---- stopwatch_mode_ctrl: IDLE/RUN/PAUSE/LAP mode FSM with event lockout ----
// ---- rev 1.0 ----
`default_nettype none

module stopwatch_mode_ctrl
  import stopwatch_mode_ctrl_pkg::*;
#(
  parameter int LOCKOUT = 4,
  parameter int LW      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_pulse,
  input  logic       ss_long,
  input  logic       lr_pulse,
  input  logic       lr_long,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_hold,
  output logic       long_sel,
  output logic [1:0] state,
  output logic [3:0] drop_cnt
);

  state_e     state_q, state_d;
  logic       count_en_q, count_en_d;
  logic       count_clr_q, count_clr_d;
  logic       lap_hold_q, lap_hold_d;
  logic       long_sel_q, long_sel_d;
  logic [3:0] drop_cnt_q, drop_cnt_d;
  event_e     ev;
  logic       busy;
  logic       accept;

  lockout_timer #(
    .LOCKOUT (LOCKOUT),
    .LW      (LW)
  ) u_lockout_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .busy  (busy)
  );

  always_comb begin
    ev          = select_event(lr_long, ss_long, ss_pulse, lr_pulse);
    state_d     = state_q;
    count_clr_d = 1'b0;
    if (!busy) begin
      case (ev)
        EV_LR_LONG: begin
          state_d     = ST_IDLE;
          count_clr_d = 1'b1;
        end
        EV_SS_LONG: begin
          if (state_q == ST_RUN || state_q == ST_LAP) begin
            state_d     = ST_IDLE;
            count_clr_d = 1'b1;
          end
        end
        EV_SS_PULSE: begin
          case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = state_q;
          endcase
        end
        EV_LR_PULSE: begin
          case (state_q)
            ST_RUN:   state_d = ST_LAP;
            ST_LAP:   state_d = ST_RUN;
            ST_PAUSE: begin
              state_d     = ST_IDLE;
              count_clr_d = 1'b1;
            end
            default:  state_d = state_q;
          endcase
        end
        default: state_d = state_q;
      endcase
    end

    // A clear in IDLE leaves the state alone but still counts as a transition.
    accept = (state_d != state_q) || count_clr_d;

    drop_cnt_d = drop_cnt_q;
    if (busy && ev != EV_NONE && drop_cnt_q != DROP_SAT)
      drop_cnt_d = drop_cnt_q + 4'd1;

    count_en_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_hold_d = (state_d == ST_LAP);
    long_sel_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      lap_hold_q  <= 1'b0;
      long_sel_q  <= 1'b0;
      drop_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      lap_hold_q  <= lap_hold_d;
      long_sel_q  <= long_sel_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign state     = state_q;
  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign lap_hold  = lap_hold_q;
  assign long_sel  = long_sel_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_mode_ctrl.sv
// ---- tb_stopwatch_mode_ctrl: directed self-checking bench ----
// ---- rev 1.0 ----
`default_nettype none

module tb_stopwatch_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss_pulse = 1'b0, ss_long = 1'b0, lr_pulse = 1'b0, lr_long = 1'b0;
  logic       count_en, count_clr, lap_hold, long_sel;
  logic [1:0] state;
  logic [3:0] drop_cnt;
  logic       z_count_en, z_count_clr, z_lap_hold, z_long_sel;
  logic [1:0] z_state;
  logic [3:0] z_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_mode_ctrl #(.LOCKOUT(4), .LW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ss_pulse(ss_pulse), .ss_long(ss_long), .lr_pulse(lr_pulse), .lr_long(lr_long),
    .count_en(count_en), .count_clr(count_clr), .lap_hold(lap_hold),
    .long_sel(long_sel), .state(state), .drop_cnt(drop_cnt)
  );

  stopwatch_mode_ctrl #(.LOCKOUT(0), .LW(3)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ss_pulse(ss_pulse), .ss_long(ss_long), .lr_pulse(lr_pulse), .lr_long(lr_long),
    .count_en(z_count_en), .count_clr(z_count_clr), .lap_hold(z_lap_hold),
    .long_sel(z_long_sel), .state(z_state), .drop_cnt(z_drop_cnt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs across a posedge; returns #1 after that edge.
  task automatic step(input logic ss, input logic sl, input logic lp, input logic ll);
    @(negedge clk);
    ss_pulse = ss; ss_long = sl; lr_pulse = lp; lr_long = ll;
    @(posedge clk);
    #1;
    ss_pulse = 1'b0; ss_long = 1'b0; lr_pulse = 1'b0; lr_long = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {6'd0, state}, 8'h0);
    check("rst_en", {7'd0, count_en}, 8'h0);
    check("rst_clr", {7'd0, count_clr}, 8'h0);
    check("rst_lap", {7'd0, lap_hold}, 8'h0);
    check("rst_lsel", {7'd0, long_sel}, 8'h0);
    check("rst_drop", {4'd0, drop_cnt}, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE -> RUN at edge N, dropped at N+3, accepted at N+5
    step(1, 0, 0, 0);
    check("run_state", {6'd0, state}, 8'h1);
    check("run_en", {7'd0, count_en}, 8'h1);
    check("run_lsel", {7'd0, long_sel}, 8'h1);
    idle(2);
    step(1, 0, 0, 0);
    check("lock_state", {6'd0, state}, 8'h1);
    check("lock_drop", {4'd0, drop_cnt}, 8'h1);
    idle(1);
    step(1, 0, 0, 0);
    check("pause_state", {6'd0, state}, 8'h2);
    check("pause_en", {7'd0, count_en}, 8'h0);
    idle(4);
    step(1, 0, 0, 0);
    check("resume_state", {6'd0, state}, 8'h1);
    idle(4);

    // RUN <-> LAP
    step(0, 0, 1, 0);
    check("lap_state", {6'd0, state}, 8'h3);
    check("lap_hold", {7'd0, lap_hold}, 8'h1);
    check("lap_en", {7'd0, count_en}, 8'h1);
    idle(4);
    step(0, 0, 1, 0);
    check("unlap_state", {6'd0, state}, 8'h1);
    check("unlap_hold", {7'd0, lap_hold}, 8'h0);
    idle(4);

    // lr_long beats ss_pulse in the same cycle
    step(1, 0, 0, 1);
    check("clr_state", {6'd0, state}, 8'h0);
    check("clr_pulse", {7'd0, count_clr}, 8'h1);
    check("clr_en", {7'd0, count_en}, 8'h0);
    check("clr_lsel", {7'd0, long_sel}, 8'h0);
    idle(1);
    check("clr_once", {7'd0, count_clr}, 8'h0);
    idle(3);

    // PAUSE + lr_pulse clears to IDLE
    step(1, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0);
    check("p2_state", {6'd0, state}, 8'h2);
    idle(4);
    step(0, 0, 1, 0);
    check("prst_state", {6'd0, state}, 8'h0);
    check("prst_clr", {7'd0, count_clr}, 8'h1);
    idle(1);
    check("prst_clr_once", {7'd0, count_clr}, 8'h0);
    idle(3);

    // ss_long in IDLE is a no-op: no clear, no lockout, no drop
    step(0, 1, 0, 0);
    check("noop_state", {6'd0, state}, 8'h0);
    check("noop_clr", {7'd0, count_clr}, 8'h0);
    check("noop_drop", {4'd0, drop_cnt}, 8'h1);
    step(1, 0, 0, 0);
    check("noop_nolock", {6'd0, state}, 8'h1);

    // 20 dropped events in total: drop_cnt saturates at 15
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("drop_mid", {4'd0, drop_cnt}, 8'h5);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    end
    check("drop_sat", {4'd0, drop_cnt}, 8'hF);
    check("sat_state", {6'd0, state}, 8'h1);

    // Async reset in LAP while locked out
    step(0, 0, 1, 0);
    check("pre_rst_lap", {6'd0, state}, 8'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", {6'd0, state}, 8'h0);
    check("arst_en", {7'd0, count_en}, 8'h0);
    check("arst_clr", {7'd0, count_clr}, 8'h0);
    check("arst_lap", {7'd0, lap_hold}, 8'h0);
    check("arst_lsel", {7'd0, long_sel}, 8'h0);
    check("arst_drop", {4'd0, drop_cnt}, 8'h0);
    @(posedge clk);
    #1;
    check("arst_hold_clr", {7'd0, count_clr}, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    check("post_rst_accept", {6'd0, state}, 8'h1);

    // LOCKOUT = 0 instance: back-to-back events all accepted
    do_reset();
    step(1, 0, 0, 0);
    check("z_s1", {6'd0, z_state}, 8'h1);
    step(1, 0, 0, 0);
    check("z_s2", {6'd0, z_state}, 8'h2);
    step(1, 0, 0, 0);
    check("z_s3", {6'd0, z_state}, 8'h1);
    step(1, 0, 0, 0);
    check("z_s4", {6'd0, z_state}, 8'h2);
    check("z_drop", {4'd0, z_drop_cnt}, 8'h0);
    step(0, 0, 0, 1);
    check("z_clr1", {7'd0, z_count_clr}, 8'h1);
    step(0, 0, 0, 1);
    check("z_clr_idle", {7'd0, z_count_clr}, 8'h1);
    check("z_idle", {6'd0, z_state}, 8'h0);
    idle(1);
    check("z_clr_end", {7'd0, z_count_clr}, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
